// File: rtl/idecode_pipe.sv
// RV32I (+ optional RV32M) instruction-decode stage with a registered control
// bundle, valid/ready handshake backed by a 2-entry skid buffer, and flush.
module idecode_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic [1:0]      out_alu_a_sel,
  output logic            out_alu_b_sel,
  output logic            out_reg_we,
  output logic [1:0]      out_wb_sel,
  output logic [2:0]      out_ld_cntr,
  output logic [1:0]      out_st_cntr,
  output logic [2:0]      out_branch,
  output logic            out_jal,
  output logic            out_jalr,
  output logic            out_illegal
);

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [1:0]      alu_a_sel;
    logic            alu_b_sel;
    logic            reg_we;
    logic [1:0]      wb_sel;
    logic [2:0]      ld_cntr;
    logic [1:0]      st_cntr;
    logic [2:0]      branch;
    logic            jal;
    logic            jalr;
    logic            illegal;
  } bundle_t;

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  bundle_t         dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = XLEN'($signed(in_instr[31:20]));
  assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
  assign shamt  = XLEN'(in_instr[24:20]);

  // Combinational decode of the arriving instruction.
  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.rd  = in_instr[11:7];
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    case (opcode)
      OPC_LOAD: begin
        dec.reg_we    = 1'b1;
        dec.wb_sel    = 2'b01;
        dec.alu_b_sel = 1'b1;
        dec.imm       = imm_i;
        case (funct3)
          3'b010:  dec.ld_cntr = 3'b000;
          3'b001:  dec.ld_cntr = 3'b001;
          3'b000:  dec.ld_cntr = 3'b010;
          3'b101:  dec.ld_cntr = 3'b011;
          3'b100:  dec.ld_cntr = 3'b100;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.alu_b_sel = 1'b1;
        dec.imm       = imm_s;
        case (funct3)
          3'b010:  dec.st_cntr = 2'b01;
          3'b001:  dec.st_cntr = 2'b10;
          3'b000:  dec.st_cntr = 2'b11;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.reg_we    = 1'b1;
        dec.alu_op    = ALU_PASSB;
        dec.alu_b_sel = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_AUIPC: begin
        dec.reg_we    = 1'b1;
        dec.alu_a_sel = 2'b01;
        dec.alu_b_sel = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_OP: begin
        dec.reg_we = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec.alu_op = base_op(funct3);
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.alu_op = ALU_SRA;
        end else if (funct7 == 7'b0000001 && ENABLE_M) begin
          case (funct3)
            3'b000:  dec.alu_op = 4'b1100;
            3'b001:  dec.alu_op = 4'b1101;
            3'b100:  dec.alu_op = 4'b1110;
            3'b110:  dec.alu_op = 4'b1111;
            default: dec.illegal = 1'b1;
          endcase
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.reg_we    = 1'b1;
        dec.alu_b_sel = 1'b1;
        dec.imm       = imm_i;
        dec.alu_op    = base_op(funct3);
        if (funct3 == 3'b001) begin
          dec.imm     = shamt;
          dec.illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec.imm = shamt;
          if (funct7 == 7'b0100000) dec.alu_op = ALU_SRA;
          else if (funct7 != 7'b0000000) dec.illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        dec.alu_op = ALU_SUB;
        dec.imm    = imm_b;
        case (funct3)
          3'b000:  dec.branch = 3'b001;
          3'b001:  dec.branch = 3'b010;
          3'b100:  dec.branch = 3'b011;
          3'b101:  dec.branch = 3'b100;
          3'b110:  dec.branch = 3'b101;
          3'b111:  dec.branch = 3'b110;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.reg_we = 1'b1;
        dec.wb_sel = 2'b10;
        dec.jal    = 1'b1;
        dec.imm    = imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          dec.reg_we    = 1'b1;
          dec.wb_sel    = 2'b10;
          dec.jalr      = 1'b1;
          dec.alu_b_sel = 1'b1;
          dec.imm       = imm_i;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal instructions must not cause architectural side effects downstream.
    if (dec.illegal) begin
      dec.reg_we  = 1'b0;
      dec.st_cntr = 2'b00;
      dec.branch  = 3'b000;
      dec.jal     = 1'b0;
      dec.jalr    = 1'b0;
    end
  end

  bundle_t main_q, main_d, skid_q, skid_d;
  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    in_ready_q, in_ready_d;
  logic    in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = main_valid_q & out_ready;

  // Skid-buffer next state; flush overrides every transfer.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_xfer) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_d = dec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_valid_q) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_valid_q;
  assign out_pc        = main_q.pc;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_imm       = main_q.imm;
  assign out_alu_op    = main_q.alu_op;
  assign out_alu_a_sel = main_q.alu_a_sel;
  assign out_alu_b_sel = main_q.alu_b_sel;
  assign out_reg_we    = main_q.reg_we;
  assign out_wb_sel    = main_q.wb_sel;
  assign out_ld_cntr   = main_q.ld_cntr;
  assign out_st_cntr   = main_q.st_cntr;
  assign out_branch    = main_q.branch;
  assign out_jal       = main_q.jal;
  assign out_jalr      = main_q.jalr;
  assign out_illegal   = main_q.illegal;

endmodule

// File: doc/idecode_pipe.md
Name: idecode_pipe

Overview:
- Parametrised next-generation instruction-decode stage for the pipelined RISC-V core.
- Decodes RV32I, plus optional RV32M, into a registered control bundle.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure never drops or duplicates instructions.
- Adds pipeline flush, an illegal-instruction flag, and a configurable datapath width for PC and immediates.

Parameters:
- XLEN, 32, width of PC and immediate outputs; legal values 32 or 64; immediates sign-extend to XLEN.
- ENABLE_M, 0, 1 decodes MUL/MULH/DIV/REM; 0 flags them illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- flush  in  1  kill all held and arriving instructions
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute stage accepts bundle
- out_pc  out  XLEN  PC of bundle
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_imm  out  XLEN  decoded immediate
- out_alu_op  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASSB, 1100 MUL, 1101 MULH, 1110 DIV, 1111 REM
- out_alu_a_sel  out  2  00 rs1, 01 pc, 10 zero
- out_alu_b_sel  out  1  0 rs2, 1 imm
- out_reg_we  out  1  register write enable
- out_wb_sel  out  2  00 alu, 01 mem, 10 pc+4
- out_ld_cntr  out  3  000 lw, 001 lh, 010 lb, 011 lhu, 100 lbu
- out_st_cntr  out  2  00 none, 01 sw, 10 sh, 11 sb
- out_branch  out  3  000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu
- out_jal, out_jalr  out  1 each  jump flags
- out_illegal  out  1  undecodable instruction

Behaviour:

Reset:
- rst=1 at a clock edge clears the main and skid valids, so out_valid=0 and in_ready=1 on the next cycle.
- All bundle fields reset to 0.
- A reset asserted mid-stall discards all held instructions.

Transfer rules:
- An input transfer occurs when in_valid & in_ready.
- An output transfer occurs when out_valid & out_ready.
- Latency is 1 cycle: a transfer at edge N makes the bundle visible on out_* after edge N.

Skid buffer and handshake:
- The stage holds two entries, MAIN (drives out_*) and SKID; in_ready = !skid_valid, registered.
- If MAIN is empty, or MAIN transfers out in the same cycle, the arriving bundle goes to MAIN.
- Otherwise the arriving bundle goes to SKID.
- When MAIN transfers out and SKID is full, SKID moves to MAIN and SKID empties.
- While out_valid=1 and out_ready=0, out_* stay stable.
- Order is strictly FIFO.

Flush:
- flush=1 at an edge clears both valids, and any instruction presented in that cycle is dropped.
- flush has priority over all transfers.

Decoding (unlisted fields are 0):
- Load (0000011): reg_we=1, wb=mem, a=rs1, b=imm, ADD, I-imm, ld_cntr from funct3. funct3 010/001/000/101/100 map to codes 000/001/010/011/100; other funct3 are illegal.
- Store (0100011): a=rs1, b=imm, ADD, S-imm. funct3 010/001/000 map to st_cntr 01/10/11; others are illegal.
- LUI: reg_we=1, PASSB, b=imm, U-imm.
- AUIPC: reg_we=1, a=pc, b=imm, ADD, U-imm.
- OP (0110011) with funct7 0000000, or 0100000 for SUB/SRA only: ALU op per funct3; a=rs1, b=rs2.
- OP with funct7=0000001 and ENABLE_M=1: funct3 000/001/100/110 map to MUL/MULH/DIV/REM; other funct3 are illegal.
- OP-IMM: same ops as OP with b=imm. SLLI/SRLI/SRAI use a zero-extended shamt = instr[24:20], and require instr[31:25] to be 0000000 (0100000 for SRAI); otherwise illegal.
- BRANCH: a=rs1, b=rs2, SUB, branch code per funct3 (000→001, 001→010, 100→011, 101→100, 110→101, 111→110), B-imm. funct3 010/011 are illegal.
- JAL: reg_we=1, wb=pc+4, jal=1, J-imm.
- JALR (funct3=000): reg_we=1, wb=pc+4, jalr=1, a=rs1, b=imm, ADD, I-imm.
- Any other opcode is illegal.
- Illegal instructions: illegal=1 and reg_we, st_cntr, branch, jal, jalr forced to 0. The bundle still flows through the handshake.
- All immediates sign-extend from instr[31] to XLEN, except shamt.

Test Plan:
- Decode addi x1,x0,-5 (0xFFB00093) → one cycle later out_valid=1, rd=1, ALU op ADD, b_sel=1, imm=0xFFFFFFFB, reg_we=1, illegal=0.
- Send 4 back-to-back instructions with out_ready=0 for 3 cycles → in_ready falls after the 2nd accept; all 4 emerge in order with no duplicates once out_ready=1.
- With 2 instructions held, assert flush for one cycle while in_valid=1 → next cycle out_valid=0, in_ready=1, and none of the three appears.
- Decode 0x00000000 → illegal=1, reg_we=0, jal=0. Decode beq 0x00208463 → branch=001, imm=8.
- Decode mul 0x02B50533: with ENABLE_M=0 → illegal=1; with ENABLE_M=1 → ALU op 1100, rd=10, rs1=10, rs2=11.
- With XLEN=64, decode lui 0x800000B7 → imm=0xFFFFFFFF80000000. Assert rst mid-stall → out_valid=0 next cycle.
